// File: rtl/urxd_1b.sv
// urxd_1b - UART byte receiver (1 start, 8 data LSB first, 1 stop, no parity).
//
// Receive-side partner of the one-byte UART transmitter. The asynchronous line
// is synchronised, a falling edge starts a frame, the start bit is validated
// at mid-bit, each following bit is sampled once per bit period, and the stop
// bit is checked before the byte is delivered.
//
// Parameters:
//   Fclk        system clock frequency in Hz
//   Fbit        line bit rate in bit/s (Nt = Fclk/Fbit clocks per bit, >= 4;
//               >= 6 when URXD_MAJ3_EN is defined)
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   URXD        asynchronous serial line, idle high
//   dat         last correctly received byte, held until the next good frame
//   ok_rx_byte  one-clock strobe: dat has just been updated
//   err_stop    one-clock strobe: stop bit sampled low (framing error)
//   en_rx_byte  high from validated start bit to the stop-bit decision
//   cb_bit      bit index: 0 = start, 1..8 = data, 9 = stop
//   ce_bit      one-clock strobe at each bit decision
//
// Build option:
//   URXD_MAJ3_EN  when defined, every decision is a 2-of-3 majority of the
//                 synchronised line around the nominal sample point, taken
//                 one clock later than the single-sample build.
`timescale 1ns/1ps

module urxd_1b #(
    parameter int Fclk = 50_000_000,
    parameter int Fbit = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       URXD,
    output logic [7:0] dat,
    output logic       ok_rx_byte,
    output logic       err_stop,
    output logic       en_rx_byte,
    output logic [3:0] cb_bit,
    output logic       ce_bit
);

    localparam int Nt = Fclk / Fbit;
    localparam logic [31:0] HALF = 32'(Nt / 2);
    localparam logic [31:0] FULL = 32'(Nt);

`ifdef URXD_MAJ3_EN
    // Decisions sit one clock after the nominal point D. The timer is
    // reloaded to 2 so the next nominal point still falls Nt clocks later.
    localparam logic [31:0] DEC_START = HALF + 32'd1;
    localparam logic [31:0] DEC_BIT   = FULL + 32'd1;
    localparam logic [31:0] RELOAD    = 32'd2;
`else
    localparam logic [31:0] DEC_START = HALF;
    localparam logic [31:0] DEC_BIT   = FULL;
    localparam logic [31:0] RELOAD    = 32'd1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    state_t      state;
    logic [31:0] cb_tact;
    logic [7:0]  sr_dat;

    logic rxs_m;
    logic rxs;
    logic rxs_d;

    logic dec_pt;
    logic smp;

    // Synchroniser and edge-detect flop. Left out of reset on purpose: they
    // must always track the real line, otherwise a reset taken while the line
    // is low would fake a falling edge.
    always_ff @(posedge clk) begin
        rxs_m <= URXD;
        rxs   <= rxs_m;
        rxs_d <= rxs;
    end

`ifdef URXD_MAJ3_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic        smp_a;
    logic        smp_b;
    logic [31:0] d_cur;

    always_comb d_cur = (state == ST_START) ? HALF : FULL;

    // Capture the line at D-1 and D; the third vote is rxs at the decision.
    always_ff @(posedge clk) begin
        if (cb_tact == d_cur - 32'd1) smp_a <= rxs;
        if (cb_tact == d_cur)         smp_b <= rxs;
    end

    always_comb smp = maj3(smp_a, smp_b, rxs);
`else
    always_comb smp = rxs;
`endif

    always_comb begin
        dec_pt = 1'b0;
        case (state)
            ST_START: dec_pt = (cb_tact == DEC_START);
            ST_DATA,
            ST_STOP:  dec_pt = (cb_tact == DEC_BIT);
            default:  dec_pt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cb_tact    <= '0;
            cb_bit     <= '0;
            sr_dat     <= '0;
            dat        <= '0;
            ok_rx_byte <= 1'b0;
            err_stop   <= 1'b0;
            en_rx_byte <= 1'b0;
            ce_bit     <= 1'b0;
        end else begin
            ce_bit     <= 1'b0;
            ok_rx_byte <= 1'b0;
            err_stop   <= 1'b0;
            if (state != ST_IDLE) cb_tact <= cb_tact + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (rxs_d && !rxs) begin
                        state   <= ST_START;
                        cb_tact <= 32'd1;
                        cb_bit  <= 4'd0;
                    end
                end
                ST_START: begin
                    if (dec_pt) begin
                        if (!smp) begin
                            state      <= ST_DATA;
                            en_rx_byte <= 1'b1;
                            cb_bit     <= 4'd1;
                            ce_bit     <= 1'b1;
                            cb_tact    <= RELOAD;
                        end else begin
                            // Line back high at mid-start: a glitch, not a frame.
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (dec_pt) begin
                        sr_dat  <= {smp, sr_dat[7:1]};
                        ce_bit  <= 1'b1;
                        cb_tact <= RELOAD;
                        cb_bit  <= cb_bit + 4'd1;
                        if (cb_bit == 4'd8) state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (dec_pt) begin
                        ce_bit     <= 1'b1;
                        cb_tact    <= RELOAD;
                        en_rx_byte <= 1'b0;
                        if (smp) begin
                            dat        <= sr_dat;
                            ok_rx_byte <= 1'b1;
                            // Leaving at mid-stop lets an early next start edge be seen.
                            state      <= ST_IDLE;
                        end else begin
                            err_stop <= 1'b1;
                            state    <= ST_BRK;
                        end
                    end
                end
                ST_BRK: begin
                    // Hold off until the line returns high so a held-low
                    // (break) line cannot retrigger a frame.
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urxd_1b.sv
`timescale 1ns/1ps

module tb_urxd_1b;

    localparam int NT = 10;

    logic       clk;
    logic       rst;
    logic       urxd;
    logic [7:0] dat;
    logic       ok_rx_byte;
    logic       err_stop;
    logic       en_rx_byte;
    logic [3:0] cb_bit;
    logic       ce_bit;

    int checks;
    int passes;

    int ok_cnt;
    int err_cnt;
    int ce_cnt;
    int en_cyc;
    int both_cnt;
    logic [7:0] okq[$];

    urxd_1b #(
        .Fclk(50_000_000),
        .Fbit(5_000_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .URXD      (urxd),
        .dat       (dat),
        .ok_rx_byte(ok_rx_byte),
        .err_stop  (err_stop),
        .en_rx_byte(en_rx_byte),
        .cb_bit    (cb_bit),
        .ce_bit    (ce_bit)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (ok_rx_byte) begin
            ok_cnt++;
            okq.push_back(dat);
        end
        if (err_stop)   err_cnt++;
        if (ce_bit)     ce_cnt++;
        if (en_rx_byte) en_cyc++;
        if (ok_rx_byte && err_stop) both_cnt++;
    end

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            urxd = 1'b1;
        end
    endtask

    task automatic drive_low(input int n);
        repeat (n) begin
            @(negedge clk);
            urxd = 1'b0;
        end
    endtask

    // One bit period; if g >= 0 the line is inverted for the single clock at offset g.
    task automatic drive_bit(input logic v, input int g);
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            urxd = (i == g) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_k);
        drive_bit(1'b0, -1);
        for (int k = 1; k <= 8; k++)
            drive_bit(b[k-1], (glitch_k == k) ? 5 : -1);
        drive_bit(stop_v, -1);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        urxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dat !== 8'h00) $display("FAIL reset_dat: got %h want 00", dat); else passes++;
        checks++; if (ok_rx_byte !== 1'b0) $display("FAIL reset_ok: got %b want 0", ok_rx_byte); else passes++;
        checks++; if (err_stop !== 1'b0) $display("FAIL reset_err: got %b want 0", err_stop); else passes++;
        checks++; if (en_rx_byte !== 1'b0) $display("FAIL reset_en: got %b want 0", en_rx_byte); else passes++;
        checks++; if (cb_bit !== 4'd0) $display("FAIL reset_cb_bit: got %0d want 0", cb_bit); else passes++;
        checks++; if (ce_bit !== 1'b0) $display("FAIL reset_ce: got %b want 0", ce_bit); else passes++;
    endtask

    task automatic test_single_a5();
        int ok0, err0, ce0;
        ok0 = ok_cnt; err0 = err_cnt; ce0 = ce_cnt;
        send_frame(8'hA5, 1'b1, -1);
        drive_idle(10);
        checks++; if (ok_cnt - ok0 !== 1) $display("FAIL a5_ok_count: got %0d want 1", ok_cnt - ok0); else passes++;
        checks++; if (dat !== 8'hA5) $display("FAIL a5_dat: got %h want a5", dat); else passes++;
        checks++; if (err_cnt - err0 !== 0) $display("FAIL a5_err_count: got %0d want 0", err_cnt - err0); else passes++;
        checks++; if (ce_cnt - ce0 !== 10) $display("FAIL a5_ce_count: got %0d want 10", ce_cnt - ce0); else passes++;
        checks++; if (en_rx_byte !== 1'b0) $display("FAIL a5_en_after: got %b want 0", en_rx_byte); else passes++;
    endtask

    // Transmitter 3% fast: 194 ns per bit instead of 200 ns, frames abutted.
    task automatic test_back_to_back();
        int ok0, err0;
        logic [7:0] frames[2];
        logic [7:0] got0, got1;
        frames[0] = 8'h00;
        frames[1] = 8'hFF;
        ok0 = ok_cnt; err0 = err_cnt;
        okq.delete();
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            urxd = 1'b0; #194;
            for (int k = 0; k < 8; k++) begin
                urxd = frames[f][k]; #194;
            end
            urxd = 1'b1; #194;
        end
        drive_idle(20);
        got0 = (okq.size() > 0) ? okq[0] : 8'hxx;
        got1 = (okq.size() > 1) ? okq[1] : 8'hxx;
        checks++; if (ok_cnt - ok0 !== 2) $display("FAIL b2b_ok_count: got %0d want 2", ok_cnt - ok0); else passes++;
        checks++; if (got0 !== 8'h00) $display("FAIL b2b_first: got %h want 00", got0); else passes++;
        checks++; if (got1 !== 8'hFF) $display("FAIL b2b_second: got %h want ff", got1); else passes++;
        checks++; if (err_cnt - err0 !== 0) $display("FAIL b2b_err_count: got %0d want 0", err_cnt - err0); else passes++;
    endtask

    task automatic test_start_glitch();
        int ok0, err0, ce0, en0;
        ok0 = ok_cnt; err0 = err_cnt; ce0 = ce_cnt; en0 = en_cyc;
        drive_low(3);
        drive_idle(25);
        checks++; if (en_cyc - en0 !== 0) $display("FAIL glitch_en: got %0d cycles want 0", en_cyc - en0); else passes++;
        checks++; if (ok_cnt - ok0 !== 0) $display("FAIL glitch_ok: got %0d want 0", ok_cnt - ok0); else passes++;
        checks++; if (err_cnt - err0 !== 0) $display("FAIL glitch_err: got %0d want 0", err_cnt - err0); else passes++;
        checks++; if (ce_cnt - ce0 !== 0) $display("FAIL glitch_ce: got %0d want 0", ce_cnt - ce0); else passes++;
        checks++; if (dat !== 8'hFF) $display("FAIL glitch_dat: got %h want ff", dat); else passes++;
    endtask

    task automatic test_framing_error();
        int ok0, err0, ce1, en1, ok1;
        ok0 = ok_cnt; err0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1);
        drive_low(3);
        ce1 = ce_cnt; en1 = en_cyc; ok1 = ok_cnt;
        drive_low(27);
        checks++; if (err_cnt - err0 !== 1) $display("FAIL fe_err_count: got %0d want 1", err_cnt - err0); else passes++;
        checks++; if (ok_cnt - ok0 !== 0) $display("FAIL fe_ok_count: got %0d want 0", ok_cnt - ok0); else passes++;
        checks++; if (dat !== 8'hFF) $display("FAIL fe_dat_held: got %h want ff", dat); else passes++;
        checks++; if ((ce_cnt - ce1) + (en_cyc - en1) + (ok_cnt - ok1) !== 0)
            $display("FAIL fe_retrigger: got %0d activity want 0", (ce_cnt - ce1) + (en_cyc - en1) + (ok_cnt - ok1));
        else passes++;
        drive_idle(10);
        send_frame(8'h81, 1'b1, -1);
        drive_idle(10);
        checks++; if (ok_cnt - ok0 !== 1) $display("FAIL fe_next_ok: got %0d want 1", ok_cnt - ok0); else passes++;
        checks++; if (dat !== 8'h81) $display("FAIL fe_next_dat: got %h want 81", dat); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int ok0, err0;
        logic [7:0] b;
        b = 8'h55;
        ok0 = ok_cnt; err0 = err_cnt;
        drive_bit(1'b0, -1);
        for (int k = 1; k <= 3; k++) drive_bit(b[k-1], -1);
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            urxd = b[3];
            rst  = (i == 5);
        end
        checks++; if (en_rx_byte !== 1'b0) $display("FAIL rst_en: got %b want 0", en_rx_byte); else passes++;
        checks++; if (cb_bit !== 4'd0) $display("FAIL rst_cb_bit: got %0d want 0", cb_bit); else passes++;
        checks++; if (dat !== 8'h00) $display("FAIL rst_dat: got %h want 00", dat); else passes++;
        drive_idle(60);
        checks++; if ((ok_cnt - ok0) + (err_cnt - err0) !== 0)
            $display("FAIL rst_no_strobe: got %0d strobes want 0", (ok_cnt - ok0) + (err_cnt - err0));
        else passes++;
        send_frame(8'h12, 1'b1, -1);
        drive_idle(10);
        checks++; if (ok_cnt - ok0 !== 1) $display("FAIL rst_next_ok: got %0d want 1", ok_cnt - ok0); else passes++;
        checks++; if (dat !== 8'h12) $display("FAIL rst_next_dat: got %h want 12", dat); else passes++;
    endtask

    task automatic test_bit_glitch();
        int ok0, ce0;
        logic [7:0] want;
`ifdef URXD_MAJ3_EN
        want = 8'hF0;
`else
        want = 8'hF4;
`endif
        ok0 = ok_cnt; ce0 = ce_cnt;
        send_frame(8'hF0, 1'b1, 3);
        drive_idle(10);
        checks++; if (ok_cnt - ok0 !== 1) $display("FAIL bg_ok_count: got %0d want 1", ok_cnt - ok0); else passes++;
        checks++; if (dat !== want) $display("FAIL bg_dat: got %h want %h", dat, want); else passes++;
        checks++; if (ce_cnt - ce0 !== 10) $display("FAIL bg_ce_count: got %0d want 10", ce_cnt - ce0); else passes++;
    endtask

    task automatic test_exclusive();
        checks++; if (both_cnt !== 0) $display("FAIL ok_err_overlap: got %0d want 0", both_cnt); else passes++;
    endtask

    initial begin
        checks = 0; passes = 0;
        ok_cnt = 0; err_cnt = 0; ce_cnt = 0; en_cyc = 0; both_cnt = 0;
        rst = 1'b1;
        urxd = 1'b1;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_start_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_bit_glitch();
        test_exclusive();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
